// File: rtl/bseq_pkg.sv
// Shared CPU package for the bit-serial sequencer: operation codes, FSM states
// and the carry-seed helper used by the serial ALU controller.
package bseq_pkg;

  typedef enum logic [2:0] {
    OP_NOP  = 3'd0,
    OP_ADD  = 3'd1,
    OP_SUB  = 3'd2,
    OP_AND  = 3'd3,
    OP_OR   = 3'd4,
    OP_XOR  = 3'd5,
    OP_PASS = 3'd6
  } op_code_t;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_LOAD  = 2'd1,
    ST_SHIFT = 2'd2,
    ST_WB    = 2'd3
  } state_t;

  // Subtraction is done as a + ~b + 1, so only SUB seeds the carry with 1.
  function automatic logic carry_seed(input op_code_t op);
    return (op == OP_SUB);
  endfunction

endpackage

// File: rtl/bseq_ctrl_if.sv
// Decoder handshake plus serial-ALU control bundle of the bit-serial sequencer.
// master = decoder/datapath side, slave = sequencer side.
interface bseq_ctrl_if
  import bseq_pkg::*;
#(
  parameter int WIDTH = 8
);
  localparam int IDX_W = (WIDTH > 1) ? $clog2(WIDTH) : 1;

  logic             op_valid;
  op_code_t         op_code;
  logic             op_ready;
  op_code_t         alu_op;
  logic             ld_en;
  logic             sh_en;
  logic [IDX_W-1:0] bit_idx;
  logic             first_bit;
  logic             last_bit;
  logic             cin_init;
  logic             wb_en;
  logic             done;

  modport master (
    output op_valid, op_code,
    input  op_ready, alu_op, ld_en, sh_en, bit_idx, first_bit, last_bit,
           cin_init, wb_en, done
  );

  modport slave (
    input  op_valid, op_code,
    output op_ready, alu_op, ld_en, sh_en, bit_idx, first_bit, last_bit,
           cin_init, wb_en, done
  );

endinterface

// File: rtl/bseq_bitcnt.sv
// LSB-first bit counter for the serial datapath with first/last decode.
// Counts only while en=1, wraps to 0 after the last bit, and is held at 0 by clr.
module bseq_bitcnt #(
  parameter  int WIDTH = 8,
  localparam int IDX_W = (WIDTH > 1) ? $clog2(WIDTH) : 1
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             clr,
  input  logic             en,
  output logic [IDX_W-1:0] bit_idx,
  output logic             at_last,
  output logic             first_bit,
  output logic             last_bit
);

  localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(WIDTH - 1);

  logic [IDX_W-1:0] idx_reg;

  always_ff @(posedge clk) begin
    if (rst || clr) begin
      idx_reg <= '0;
    end else if (en) begin
      idx_reg <= (idx_reg == LAST_IDX) ? '0 : idx_reg + 1'b1;
    end
  end

  // at_last is unqualified so the FSM can use it without looping through sh_en.
  assign bit_idx   = idx_reg;
  assign at_last   = (idx_reg == LAST_IDX);
  assign first_bit = en && (idx_reg == '0);
  assign last_bit  = en && at_last;

endmodule

// File: rtl/bseq_ctrl.sv
// Bit-serial ALU sequencer: IDLE -> LOAD -> SHIFT (WIDTH cycles) -> WB.
// Optional BSEQ_STALL_EN adds a stall input that freezes LOAD/SHIFT progress.
module bseq_ctrl
  import bseq_pkg::*;
#(
  parameter int WIDTH = 8
) (
  input  logic clk,
  input  logic rst,
`ifdef BSEQ_STALL_EN
  input  logic stall,
`endif
  bseq_ctrl_if.slave bus
);

  localparam int IDX_W = (WIDTH > 1) ? $clog2(WIDTH) : 1;

  state_t           state_reg;
  state_t           state_next;
  op_code_t         alu_op_reg;
  logic             accept;
  logic             ld_en_next;
  logic             sh_en_next;
  logic             wb_en_next;
  logic             done_next;
  logic             ready_next;
  logic             stall_w;
  logic             cnt_clr;
  logic             at_last;
  logic [IDX_W-1:0] idx;
  logic             first_w;
  logic             last_w;

`ifdef BSEQ_STALL_EN
  assign stall_w = stall;
`else
  assign stall_w = 1'b0;
`endif

  always_ff @(posedge clk) begin
    if (rst) begin
      state_reg  <= ST_IDLE;
      alu_op_reg <= OP_NOP;
    end else begin
      state_reg <= state_next;
      if (accept) begin
        alu_op_reg <= bus.op_code;
      end
    end
  end

  always_comb begin
    state_next = state_reg;
    accept     = 1'b0;
    ld_en_next = 1'b0;
    sh_en_next = 1'b0;
    wb_en_next = 1'b0;
    done_next  = 1'b0;
    ready_next = 1'b0;
    case (state_reg)
      ST_IDLE: begin
        ready_next = 1'b1;
        if (bus.op_valid) begin
          accept     = 1'b1;
          state_next = (bus.op_code == OP_NOP) ? ST_WB : ST_LOAD;
        end
      end
      ST_LOAD: begin
        if (!stall_w) begin
          ld_en_next = 1'b1;
          state_next = ST_SHIFT;
        end
      end
      ST_SHIFT: begin
        if (!stall_w) begin
          sh_en_next = 1'b1;
          if (at_last) begin
            state_next = ST_WB;
          end
        end
      end
      ST_WB: begin
        // A NOP reaches WB only to signal completion; nothing is written back.
        done_next  = 1'b1;
        wb_en_next = (alu_op_reg != OP_NOP);
        state_next = ST_IDLE;
      end
      default: begin
        state_next = ST_IDLE;
      end
    endcase
  end

  // Counter is held at zero outside SHIFT, so every operation starts at bit 0.
  assign cnt_clr = (state_reg != ST_SHIFT);

  bseq_bitcnt #(
    .WIDTH (WIDTH)
  ) u_bitcnt (
    .clk       (clk),
    .rst       (rst),
    .clr       (cnt_clr),
    .en        (sh_en_next),
    .bit_idx   (idx),
    .at_last   (at_last),
    .first_bit (first_w),
    .last_bit  (last_w)
  );

  assign bus.op_ready  = ready_next;
  assign bus.alu_op    = alu_op_reg;
  assign bus.ld_en     = ld_en_next;
  assign bus.sh_en     = sh_en_next;
  assign bus.wb_en     = wb_en_next;
  assign bus.done      = done_next;
  assign bus.bit_idx   = idx;
  assign bus.first_bit = first_w;
  assign bus.last_bit  = last_w;
  assign bus.cin_init  = first_w && carry_seed(alu_op_reg);

endmodule

// File: tb/tb_bseq_ctrl.sv
// Directed cycle-by-cycle bench for bseq_ctrl (WIDTH=8); the stall scenario
// is exercised only when BSEQ_STALL_EN is defined.
module tb_bseq_ctrl;
  import bseq_pkg::*;

  localparam int WIDTH = 8;

  logic clk = 1'b0;
  logic rst;
  logic stall;
  int   errors = 0;
  int   checks = 0;

  bseq_ctrl_if #(.WIDTH(WIDTH)) bus ();

  bseq_ctrl #(
    .WIDTH (WIDTH)
  ) dut (
    .clk   (clk),
    .rst   (rst),
`ifdef BSEQ_STALL_EN
    .stall (stall),
`endif
    .bus   (bus.slave)
  );

  always #5 clk = ~clk;

  initial begin
    #100000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog expired");
  end

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Drives one operation from acceptance (cycle 0) to the first IDLE cycle,
  // checking every output against the expected timeline. Optional features:
  // keep op_valid high with changing op_code, reset at a given bit, stall at a given bit.
  task automatic run_op(input op_code_t op, input string tag, input bit hold,
                        input int abort_at, input int stall_at, input int stall_len);
    bus.op_valid = 1'b1;
    bus.op_code  = op;
    check_eq({tag, " ready c0"}, bus.op_ready, 1);
    tick();
    bus.op_valid = hold;
    bus.op_code  = OP_NOP;
    if (op == OP_NOP) begin
      check_eq({tag, " done c1"}, bus.done, 1);
      check_eq({tag, " wb_en c1"}, bus.wb_en, 0);
      check_eq({tag, " ld_en c1"}, bus.ld_en, 0);
      check_eq({tag, " ready c1"}, bus.op_ready, 0);
      bus.op_valid = 1'b0;
      tick();
      check_eq({tag, " ready c2"}, bus.op_ready, 1);
      check_eq({tag, " done c2"}, bus.done, 0);
      $display("txn %s op=%0d complete", tag, op);
      return;
    end
    check_eq({tag, " ld_en load"}, bus.ld_en, 1);
    check_eq({tag, " sh_en load"}, bus.sh_en, 0);
    check_eq({tag, " ready load"}, bus.op_ready, 0);
    check_eq({tag, " alu_op load"}, bus.alu_op, op);
    tick();
    for (int k = 0; k < WIDTH; k++) begin
      if (hold) bus.op_code = op_code_t'(3'(k + 1));
`ifdef BSEQ_STALL_EN
      if (k == stall_at) begin
        for (int s = 0; s < stall_len; s++) begin
          stall = 1'b1;
          check_eq({tag, " sh_en stall"}, bus.sh_en, 0);
          check_eq({tag, " bit_idx stall"}, bus.bit_idx, k);
          check_eq({tag, " ready stall"}, bus.op_ready, 0);
          check_eq({tag, " wb_en stall"}, bus.wb_en, 0);
          tick();
        end
        stall = 1'b0;
      end
`endif
      if (k == abort_at) begin
        rst = 1'b1;
        check_eq({tag, " sh_en pre-rst"}, bus.sh_en, 1);
        check_eq({tag, " bit_idx pre-rst"}, bus.bit_idx, k);
        tick();
        rst = 1'b0;
        check_eq({tag, " ready post-rst"}, bus.op_ready, 1);
        check_eq({tag, " sh_en post-rst"}, bus.sh_en, 0);
        check_eq({tag, " wb_en post-rst"}, bus.wb_en, 0);
        check_eq({tag, " done post-rst"}, bus.done, 0);
        check_eq({tag, " bit_idx post-rst"}, bus.bit_idx, 0);
        check_eq({tag, " alu_op post-rst"}, bus.alu_op, OP_NOP);
        tick();
        check_eq({tag, " done after abort"}, bus.done, 0);
        check_eq({tag, " wb_en after abort"}, bus.wb_en, 0);
        check_eq({tag, " ld_en after abort"}, bus.ld_en, 0);
        $display("txn %s op=%0d aborted at bit %0d", tag, op, k);
        return;
      end
      check_eq({tag, " sh_en shift"}, bus.sh_en, 1);
      check_eq({tag, " bit_idx shift"}, bus.bit_idx, k);
      check_eq({tag, " first_bit"}, bus.first_bit, (k == 0));
      check_eq({tag, " last_bit"}, bus.last_bit, (k == WIDTH - 1));
      check_eq({tag, " cin_init"}, bus.cin_init, (op == OP_SUB) && (k == 0));
      check_eq({tag, " ld_en shift"}, bus.ld_en, 0);
      check_eq({tag, " wb_en shift"}, bus.wb_en, 0);
      check_eq({tag, " ready shift"}, bus.op_ready, 0);
      check_eq({tag, " alu_op shift"}, bus.alu_op, op);
      tick();
    end
    bus.op_valid = 1'b0;
    check_eq({tag, " wb_en wb"}, bus.wb_en, 1);
    check_eq({tag, " done wb"}, bus.done, 1);
    check_eq({tag, " sh_en wb"}, bus.sh_en, 0);
    check_eq({tag, " bit_idx wb"}, bus.bit_idx, 0);
    check_eq({tag, " alu_op wb"}, bus.alu_op, op);
    tick();
    check_eq({tag, " ready idle"}, bus.op_ready, 1);
    check_eq({tag, " done idle"}, bus.done, 0);
    check_eq({tag, " wb_en idle"}, bus.wb_en, 0);
    check_eq({tag, " alu_op idle"}, bus.alu_op, op);
    $display("txn %s op=%0d complete", tag, op);
  endtask

  initial begin
    rst          = 1'b1;
    stall        = 1'b0;
    bus.op_valid = 1'b0;
    bus.op_code  = OP_NOP;
    repeat (3) tick();
    check_eq("reset ready", bus.op_ready, 1);
    check_eq("reset alu_op", bus.alu_op, OP_NOP);
    check_eq("reset ld_en", bus.ld_en, 0);
    check_eq("reset sh_en", bus.sh_en, 0);
    check_eq("reset wb_en", bus.wb_en, 0);
    check_eq("reset done", bus.done, 0);
    check_eq("reset cin_init", bus.cin_init, 0);
    check_eq("reset bit_idx", bus.bit_idx, 0);
    rst = 1'b0;
    $display("txn reset complete");

    run_op(OP_ADD,  "add",       1'b0, -1, -1, 0);
    run_op(OP_SUB,  "sub",       1'b0, -1, -1, 0);
    run_op(OP_AND,  "and",       1'b0, -1, -1, 0);
    run_op(OP_NOP,  "nop",       1'b0, -1, -1, 0);
    run_op(OP_XOR,  "xor_hold",  1'b1, -1, -1, 0);
    run_op(OP_ADD,  "add_abort", 1'b0,  4, -1, 0);
    run_op(OP_ADD,  "add_after", 1'b0, -1, -1, 0);
`ifdef BSEQ_STALL_EN
    run_op(OP_PASS, "pass_stall", 1'b0, -1, 3, 3);
`endif

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
